// File: rtl/phoneme_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : phoneme_scheduler
//  Purpose  : Queues phoneme codes from the picoblaze side and plays them back
//             one at a time. Each code is looked up in an external address
//             table. Entries whose end address is below the start address are
//             rejected. Valid entries launch a single playback with the flash
//             start/end address.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   system clock, rising edge
//    reset           in   synchronous active-high reset
//    phon_valid      in   phoneme code offered
//    phon_code       in   phoneme code [CODE_W]
//    phon_ready      out  FIFO can accept a code this cycle
//    lut_addr        out  phoneme table index [CODE_W]
//    lut_start       in   table start address [24], one cycle after lut_addr
//    lut_end         in   table end address [24], one cycle after lut_addr
//    play_start      out  one-cycle playback launch pulse
//    play_start_addr out  flash start address, stable during playback [24]
//    play_end_addr   out  flash end address, stable during playback [24]
//    play_done       in   one-cycle playback finished pulse
//    busy            out  scheduler is not idle
//    fifo_count      out  number of queued codes [5]
//    bad_entry       out  one-cycle pulse: table entry rejected
// ============================================================================
module phoneme_scheduler #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phon_valid,
  input  logic [CODE_W-1:0] phon_code,
  output logic              phon_ready,
  output logic [CODE_W-1:0] lut_addr,
  input  logic [23:0]       lut_start,
  input  logic [23:0]       lut_end,
  output logic              play_start,
  output logic [23:0]       play_start_addr,
  output logic [23:0]       play_end_addr,
  input  logic              play_done,
  output logic              busy,
  output logic [4:0]        fifo_count,
  output logic              bad_entry
);

  // DEPTH is a power of two, so a pointer of PTR_W bits wraps modulo DEPTH
  // by simple overflow.
  localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_START  = 3'd3,
    ST_PLAY   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [CODE_W-1:0] mem_q [DEPTH];

  state_t            state_q,      state_d;
  logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
  logic [4:0]        count_q,      count_d;
  logic              phon_ready_q, phon_ready_d;
  logic [CODE_W-1:0] lut_addr_q,   lut_addr_d;
  logic              play_start_q, play_start_d;
  logic [23:0]       start_addr_q, start_addr_d;
  logic [23:0]       end_addr_q,   end_addr_d;
  logic              busy_q,       busy_d;
  logic              bad_q,        bad_d;

  logic              w_push;
  logic              w_pop;

  // phon_ready_q always equals (count_q < DEPTH). It is registered, so the
  // accept decision never depends on a combinational path through this
  // cycle's pop.
  assign w_push = phon_valid && phon_ready_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    lut_addr_d   = lut_addr_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    play_start_d = 1'b0;
    bad_d        = 1'b0;
    w_pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The pop happens here, so a finished playback always spends at
        // least one cycle in IDLE before the next code leaves the FIFO.
        if (count_q != 5'd0) begin
          w_pop      = 1'b1;
          lut_addr_d = mem_q[rd_ptr_q];
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // The table answers one cycle after the address is presented.
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (lut_end < lut_start) begin
          bad_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          start_addr_d = lut_start;
          end_addr_d   = lut_end;
          // Register the pulse now so it is high for exactly the START cycle.
          play_start_d = 1'b1;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (play_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    phon_ready_d = (count_d < DEPTH_CNT);
    busy_d       = (state_d != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 5'd0;
      phon_ready_q <= 1'b1;
      lut_addr_q   <= '0;
      play_start_q <= 1'b0;
      start_addr_q <= 24'd0;
      end_addr_q   <= 24'd0;
      busy_q       <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      phon_ready_q <= phon_ready_d;
      lut_addr_q   <= lut_addr_d;
      play_start_q <= play_start_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      busy_q       <= busy_d;
      bad_q        <= bad_d;
    end
  end

  // FIFO storage needs no reset. An emptied FIFO is defined by count and
  // the pointers, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= phon_code;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign phon_ready      = phon_ready_q;
  assign lut_addr        = lut_addr_q;
  assign play_start      = play_start_q;
  assign play_start_addr = start_addr_q;
  assign play_end_addr   = end_addr_q;
  assign busy            = busy_q;
  assign fifo_count      = count_q;
  assign bad_entry       = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_phoneme_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phoneme_scheduler
//  Purpose  : Self-checking bench for phoneme_scheduler. The expected playback
//             or reject event is queued when each code is pushed. A monitor
//             pops and compares an entry whenever play_start or bad_entry
//             fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phoneme_scheduler;

  logic        clk;
  logic        reset;
  logic        phon_valid;
  logic [5:0]  phon_code;
  logic        phon_ready;
  logic [5:0]  lut_addr;
  logic [23:0] lut_start;
  logic [23:0] lut_end;
  logic        play_start;
  logic [23:0] play_start_addr;
  logic [23:0] play_end_addr;
  logic        play_done;
  logic        busy;
  logic [4:0]  fifo_count;
  logic        bad_entry;

  phoneme_scheduler #(.DEPTH(8), .CODE_W(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .phon_valid      (phon_valid),
    .phon_code       (phon_code),
    .phon_ready      (phon_ready),
    .lut_addr        (lut_addr),
    .lut_start       (lut_start),
    .lut_end         (lut_end),
    .play_start      (play_start),
    .play_start_addr (play_start_addr),
    .play_end_addr   (play_end_addr),
    .play_done       (play_done),
    .busy            (busy),
    .fifo_count      (fifo_count),
    .bad_entry       (bad_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_events = 0;

  typedef struct {
    logic        bad;
    logic [23:0] s;
    logic [23:0] e;
  } exp_t;
  exp_t expq[$];

  // Phoneme address table: code 5 is the reference entry, code 7 is
  // inverted (rejected), and code 9 is a one-word phoneme.
  function automatic logic [47:0] tbl(input logic [5:0] c);
    logic [23:0] s;
    logic [23:0] e;
    case (c)
      6'd5: begin s = 24'h000100; e = 24'h0001FF; end
      6'd7: begin s = 24'h000200; e = 24'h0001FF; end
      6'd9: begin s = 24'h000300; e = 24'h000300; end
      default: begin s = {10'h0, c, 8'h00}; e = s + 24'h0000FF; end
    endcase
    return {s, e};
  endfunction

  // The external table responds one cycle after the address.
  always @(posedge clk) begin
    {lut_start, lut_end} <= tbl(lut_addr);
  end

  task automatic push_exp(input logic [5:0] c);
    exp_t x;
    logic [47:0] t;
    t = tbl(c);
    x.s = t[47:24];
    x.e = t[23:0];
    x.bad = (x.e < x.s);
    expq.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard comparison on every DUT output event.
  always @(negedge clk) begin
    exp_t x;
    if (!reset && (play_start || bad_entry)) begin
      n_events++;
      n_tests++;
      if (play_start && bad_entry) begin
        n_fail++;
        $display("FAIL event_both: play_start and bad_entry both high, expected one");
      end else if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL event_unexpected: play_start=%0b bad_entry=%0b, expected no event",
                 play_start, bad_entry);
      end else begin
        x = expq.pop_front();
        if (x.bad !== bad_entry ||
            (!x.bad && (play_start_addr !== x.s || play_end_addr !== x.e))) begin
          n_fail++;
          $display("FAIL event_cmp: got bad=%0b start=0x%0h end=0x%0h, expected bad=%0b start=0x%0h end=0x%0h",
                   bad_entry, play_start_addr, play_end_addr, x.bad, x.s, x.e);
        end
      end
    end
  end

  task automatic wait_play_start();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (play_start) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_play_start: timeout, expected play_start within 20 cycles");
    end
  endtask

  task automatic pulse_done();
    play_done = 1'b1;
    step();
    play_done = 1'b0;
  endtask

  // Answer each playback with play_done until the scheduler drains.
  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      if (play_start) begin
        step();
        pulse_done();
      end
      if (fifo_count == 5'd0 && !busy) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: timeout, expected empty and idle within 600 cycles");
    end
  endtask

  initial begin
    int ev0;
    reset      = 1'b1;
    phon_valid = 1'b0;
    phon_code  = 6'd0;
    play_done  = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst_count",      48'(fifo_count),      48'd0);
    chk("rst_ready",      48'(phon_ready),      48'd1);
    chk("rst_busy",       48'(busy),            48'd0);
    chk("rst_play_start", 48'(play_start),      48'd0);
    chk("rst_bad",        48'(bad_entry),       48'd0);
    chk("rst_lut_addr",   48'(lut_addr),        48'd0);
    chk("rst_start_addr", 48'(play_start_addr), 48'd0);
    chk("rst_end_addr",   48'(play_end_addr),   48'd0);
    reset = 1'b0;

    // Single phoneme 0x05: lookup, latency, held addresses
    phon_valid = 1'b1; phon_code = 6'd5; push_exp(6'd5);
    step();
    phon_valid = 1'b0;
    chk("p5_count_after_push", 48'(fifo_count), 48'd1);
    step();
    chk("p5_lut_addr",  48'(lut_addr),   48'd5);
    chk("p5_busy",      48'(busy),       48'd1);
    chk("p5_count_pop", 48'(fifo_count), 48'd0);
    step();
    chk("p5_no_start_check", 48'(play_start), 48'd0);
    step();
    chk("p5_play_start", 48'(play_start),      48'd1);
    chk("p5_start_addr", 48'(play_start_addr), 48'h000100);
    chk("p5_end_addr",   48'(play_end_addr),   48'h0001FF);
    step();
    chk("p5_pulse_len",  48'(play_start),      48'd0);
    chk("p5_hold_start", 48'(play_start_addr), 48'h000100);
    chk("p5_hold_end",   48'(play_end_addr),   48'h0001FF);
    chk("p5_hold_lut",   48'(lut_addr),        48'd5);
    pulse_done();
    chk("p5_idle", 48'(busy), 48'd0);

    // Fill the FIFO during PLAY, drop the ninth push, then drain. The queue
    // holds a rejected entry (0x07) and a one-word entry (0x09).
    phon_valid = 1'b1; phon_code = 6'h11; push_exp(6'h11);
    step();
    phon_valid = 1'b0;
    wait_play_start();
    phon_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      case (i)
        2: phon_code = 6'h07;
        4: phon_code = 6'h09;
        default: phon_code = 6'(6'h20 + i);
      endcase
      push_exp(phon_code);
      step();
    end
    chk("full_count", 48'(fifo_count), 48'd8);
    chk("full_ready", 48'(phon_ready), 48'd0);
    phon_code = 6'h28;
    step();
    phon_valid = 1'b0;
    chk("full_drop_count", 48'(fifo_count), 48'd8);
    pulse_done();
    chk("full_idle_busy", 48'(busy), 48'd0);
    step();
    chk("full_pop_count", 48'(fifo_count), 48'd7);
    chk("full_pop_ready", 48'(phon_ready), 48'd1);
    drain();

    // Push in the same cycle as the IDLE pop with one code queued
    phon_valid = 1'b1;
    phon_code = 6'h12; push_exp(6'h12);
    step();
    chk("pp_count_first", 48'(fifo_count), 48'd1);
    phon_code = 6'h13; push_exp(6'h13);
    step();
    phon_valid = 1'b0;
    chk("pp_count_same", 48'(fifo_count), 48'd1);
    chk("pp_lut_addr",   48'(lut_addr),   48'h12);
    drain();

    // play_done in IDLE and in LOOKUP is ignored
    pulse_done();
    chk("ign_idle_busy", 48'(busy), 48'd0);
    phon_valid = 1'b1; phon_code = 6'h0A; push_exp(6'h0A);
    step();
    phon_valid = 1'b0;
    step();
    chk("ign_lookup_addr", 48'(lut_addr), 48'h0A);
    pulse_done();
    chk("ign_check_busy",  48'(busy),       48'd1);
    chk("ign_check_start", 48'(play_start), 48'd0);
    step();
    chk("ign_start", 48'(play_start), 48'd1);
    step();
    pulse_done();
    chk("ign_done_idle", 48'(busy), 48'd0);

    // Reset in PLAY with three queued codes
    phon_valid = 1'b1; phon_code = 6'h30; push_exp(6'h30);
    step();
    phon_valid = 1'b0;
    wait_play_start();
    phon_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      phon_code = 6'(6'h31 + i);
      push_exp(phon_code);
      step();
    end
    phon_valid = 1'b0;
    chk("rp_count_before", 48'(fifo_count), 48'd3);
    reset = 1'b1;
    expq.delete();
    step();
    chk("rp_count", 48'(fifo_count), 48'd0);
    chk("rp_busy",  48'(busy),       48'd0);
    chk("rp_ready", 48'(phon_ready), 48'd1);
    reset = 1'b0;
    ev0 = n_events;
    step();
    pulse_done();
    repeat (10) step();
    chk("rp_no_event", 48'(n_events - ev0), 48'd0);
    chk("rp_idle",     48'(busy),           48'd0);

    chk("sb_empty", 48'(expq.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
